// File: rtl/aes_pkg.sv
// Shared AES-side definitions: block size, key-size modes, loader error codes
// and the loader state encoding.
package aes_pkg;

   localparam int BLOCK_BYTES = 16;

   localparam logic [1:0] MODE_128  = 2'b00;
   localparam logic [1:0] MODE_192  = 2'b01;
   localparam logic [1:0] MODE_256  = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_SHORT   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_MODE    = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } loader_state_e;

endpackage

// File: rtl/aes_block_loader_if.sv
// Byte-stream input, block handoff and frame-status signals of the AES block loader.
// master = stream source / block consumer, slave = the loader itself.
interface aes_block_loader_if #(
   parameter int BLOCK_BYTES = 16
);
   localparam int BC_W = $clog2(BLOCK_BYTES + 1);

   logic                     in_valid;
   logic [7:0]               in_data;
   logic                     in_last;
   logic [1:0]               in_mode;
   logic                     in_ready;
   logic                     blk_valid;
   logic                     blk_ready;
   logic [8*BLOCK_BYTES-1:0] blk_data;
   logic [1:0]               blk_mode;
   logic                     frame_err;
   logic [1:0]               err_code;
   logic [BC_W-1:0]          byte_cnt;

   modport master (
      output in_valid, in_data, in_last, in_mode, blk_ready,
      input  in_ready, blk_valid, blk_data, blk_mode, frame_err, err_code, byte_cnt
   );

   modport slave (
      input  in_valid, in_data, in_last, in_mode, blk_ready,
      output in_ready, blk_valid, blk_data, blk_mode, frame_err, err_code, byte_cnt
   );

endinterface

// File: rtl/aes_block_loader_gap_timer.sv
// Clearable, saturating idle-gap counter; tc flags that TIMEOUT_CYCLES idle
// cycles have elapsed. TIMEOUT_CYCLES = 0 disables the flag entirely.
module gap_timer #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != TERM)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign tc = (TIMEOUT_CYCLES != 0) && (cnt_q == TERM);

endmodule

// File: rtl/aes_block_loader.sv
// Deserializes a byte stream into one AES block plus key-size mode and hands it
// to a cipher core over valid/ready; discards short, timed-out and bad-mode frames.
//
//   state | meaning
//   IDLE  | waiting for the first byte of a frame
//   FILL  | collecting bytes 1..BLOCK_BYTES-1, gap timer running
//   HOLD  | block complete, blk_valid high until blk_ready
module aes_block_loader #(
   parameter int BLOCK_BYTES    = aes_pkg::BLOCK_BYTES,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   aes_block_loader_if.slave bus
);
   import aes_pkg::*;

   localparam int BC_W = $clog2(BLOCK_BYTES + 1);
   localparam int DW   = 8 * BLOCK_BYTES;

   loader_state_e   state_q, state_d;
   logic [DW-1:0]   blk_data_q, blk_data_d;
   logic [1:0]      blk_mode_q, blk_mode_d;
   logic [1:0]      err_code_q, err_code_d;
   logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
   logic            frame_err_q, frame_err_d;

   logic accept;
   logic timeout;
   logic gap_clr;
   logic gap_en;
   int   wr_pos;

   assign accept  = bus.in_valid && (state_q != HOLD);
   assign gap_en  = (state_q == FILL);
   assign gap_clr = accept || (state_q != FILL);

   gap_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_gap_timer (
      .clk  (clk),
      .reset(reset),
      .clr  (gap_clr),
      .en   (gap_en),
      .tc   (timeout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         blk_data_q  <= '0;
         blk_mode_q  <= '0;
         err_code_q  <= '0;
         byte_cnt_q  <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         blk_data_q  <= blk_data_d;
         blk_mode_q  <= blk_mode_d;
         err_code_q  <= err_code_d;
         byte_cnt_q  <= byte_cnt_d;
         frame_err_q <= frame_err_d;
      end
   end

   // First byte lands in the top byte lane (FIPS-197 hex ordering).
   always_comb begin
      state_d     = state_q;
      blk_data_d  = blk_data_q;
      blk_mode_d  = blk_mode_q;
      err_code_d  = err_code_q;
      byte_cnt_d  = byte_cnt_q;
      frame_err_d = 1'b0;
      wr_pos      = BLOCK_BYTES - 1 - int'(byte_cnt_q);

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.in_mode == MODE_RSVD) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_MODE;
               end else begin
                  blk_data_d[8*wr_pos +: 8] = bus.in_data;
                  blk_mode_d                = bus.in_mode;
                  if (bus.in_last) begin
                     frame_err_d = 1'b1;
                     err_code_d  = ERR_SHORT;
                     byte_cnt_d  = '0;
                  end else begin
                     byte_cnt_d = BC_W'(1);
                     state_d    = FILL;
                  end
               end
            end
         end

         FILL: begin
            if (accept) begin
               blk_data_d[8*wr_pos +: 8] = bus.in_data;
               if (byte_cnt_q == BC_W'(BLOCK_BYTES - 1)) begin
                  byte_cnt_d = BC_W'(BLOCK_BYTES);
                  state_d    = HOLD;
               end else if (bus.in_last) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_SHORT;
                  byte_cnt_d  = '0;
                  state_d     = IDLE;
               end else begin
                  byte_cnt_d = byte_cnt_q + BC_W'(1);
               end
            end else if (timeout) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_TIMEOUT;
               byte_cnt_d  = '0;
               state_d     = IDLE;
            end
         end

         HOLD: begin
            if (bus.blk_ready) begin
               byte_cnt_d = '0;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = (state_q != HOLD);
   assign bus.blk_valid = (state_q == HOLD);
   assign bus.blk_data  = blk_data_q;
   assign bus.blk_mode  = blk_mode_q;
   assign bus.frame_err = frame_err_q;
   assign bus.err_code  = err_code_q;
   assign bus.byte_cnt  = byte_cnt_q;

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
Input-side counterpart to the AES self-test top, which drives fixed blocks into the cipher/decipher cores and serializes results out to the 7-segment display. This block does the reverse: it deserializes a byte stream into a 128-bit AES block plus a key-size mode. It then hands the block to a cipher/decipher core over a valid/ready handshake. It also detects short frames and inter-byte timeouts.

Parameters:
BLOCK_BYTES, 16, bytes per AES block; the output width is 8*BLOCK_BYTES.
TIMEOUT_CYCLES, 1000, maximum idle cycles between accepted bytes inside a frame; 0 disables the timeout.
CNT_W, 16, width of the internal gap counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  byte present on in_data.
in_data  input  8  stream byte.
in_last  input  1  frame-end marker, qualified by in_valid.
in_mode  input  2  key size: 00=128, 01=192, 10=256, 11=reserved.
in_ready  output  1  loader can accept a byte.
blk_valid  output  1  assembled block available.
blk_ready  input  1  consumer accepts the block.
blk_data  output  128  assembled block.
blk_mode  output  2  mode captured with the block.
frame_err  output  1  one-cycle pulse on a discarded frame.
err_code  output  2  01=short frame, 10=timeout, 11=reserved mode; holds until the next error.
byte_cnt  output  5  bytes accepted in the current frame, 0..16.

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE, in_ready=1, blk_valid=0;
  - blk_data=0, blk_mode=0, frame_err=0, err_code=0, byte_cnt=0, gap counter=0.
- A byte is accepted when in_valid & in_ready.
- States:
  - IDLE:
    - in_ready=1.
    - On the first accept: write the byte to blk_data[127:120], capture in_mode into blk_mode, set byte_cnt=1, go to FILL.
    - If in_mode=11 on the first byte: discard it, pulse frame_err with err_code=11, stay in IDLE.
  - FILL:
    - in_ready=1.
    - The k-th accepted byte (k=0..15) goes to blk_data[127-8k -: 8]. The first byte is the MSB, matching FIPS-197 hex ordering.
    - Each accept increments byte_cnt and clears the gap counter; otherwise the gap counter increments.
    - in_mode is ignored after the first byte.
  - HOLD:
    - in_ready=0, blk_valid=1.
    - blk_data and blk_mode stay stable until blk_ready.
- Completion:
  - The 16th accept moves the block to HOLD; blk_valid rises on the next cycle (latency 1 clock from the last byte).
  - byte_cnt reads 16 while in HOLD.
- Handshake:
  - blk_valid & blk_ready → IDLE on the next edge: blk_valid=0, byte_cnt=0, in_ready=1.
  - No byte is accepted in the same cycle as the block handoff.
  - blk_ready while blk_valid=0 is ignored.
- in_last:
  - Asserted with the 16th byte: normal completion.
  - Asserted with byte k<16: frame discarded, frame_err pulses for 1 cycle, err_code=01, byte_cnt=0, back to IDLE.
  - blk_data is not cleared on discard, but blk_valid never rises for that frame.
- Timeout:
  - In FILL with TIMEOUT_CYCLES>0, when the gap counter reaches TIMEOUT_CYCLES with no accept: discard, frame_err pulse, err_code=10, IDLE.
  - If an accept and the timeout coincide in the same cycle, the accept wins and the counter clears.
- No timeout applies in HOLD; back-pressure there is unlimited.
- Reset mid-frame or mid-HOLD: immediate return to the reset values, and any partial block is lost.
- Widths: byte_cnt saturates logically at 16. The gap counter stops incrementing once it reaches TIMEOUT_CYCLES.

Decomposition:
- Shared package aes_pkg holds:
  - BLOCK_BYTES=16;
  - mode constants MODE_128=2'b00, MODE_192=2'b01, MODE_256=2'b10;
  - error codes ERR_SHORT=2'b01, ERR_TIMEOUT=2'b10, ERR_MODE=2'b11;
  - the loader state enum {IDLE, FILL, HOLD}.
- One natural sub-module, gap_timer: a clearable, saturating up-counter with terminal flag, parameterised by TIMEOUT_CYCLES and CNT_W.

Test Plan:
- Send 16 back-to-back bytes 00,11,...,ff with in_mode=00 and blk_ready=1 → blk_valid for 1 cycle, 1 clock after the last byte; blk_data=128'h00112233445566778899aabbccddeeff; blk_mode=00.
- Same stream with blk_ready=0 for 20 cycles → in_ready=0, blk_data stable, byte_cnt=16. Raising blk_ready → IDLE and in_ready=1 on the next cycle.
- 5 bytes, then in_last on the 6th → frame_err pulses exactly 1 cycle, err_code=01, byte_cnt=0, no blk_valid. A following full frame assembles correctly.
- TIMEOUT_CYCLES=8: 3 bytes, then idle for 8 cycles → frame_err with err_code=10. The next byte is treated as byte 0.
- First byte with in_mode=11 → frame_err, err_code=11, state stays IDLE. Also assert reset mid-frame after 7 bytes → all outputs return to reset values asynchronously.
- First byte with in_mode=10, in_mode switched to 01 mid-frame → blk_mode=10 on completion.
